// File: rtl/edge_detect_multi.sv
// Multi-channel synchronizer + debouncer with per-channel edge selection,
// sticky pending/overrun flags and a combined interrupt request.
module edge_detect_multi #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   signal,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clr,
  output logic [CHANNELS-1:0]   level,
  output logic [CHANNELS-1:0]   tick,
  output logic [CHANNELS-1:0]   pending,
  output logic [CHANNELS-1:0]   overrun,
  output logic                  irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  genvar g;
  generate
    for (g = 0; g < CHANNELS; g = g + 1) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_r;
      logic [CW-1:0]          cnt_r;
      logic                   level_r;
      logic                   tick_r;
      logic                   pend_r;
      logic                   ovr_r;
      logic                   sync_bit;
      logic                   update;
      logic                   tick_next;

      assign sync_bit = sync_r[SYNC_STAGES-1];

      // The new level equals sync_bit at an update, so sync_bit selects the
      // rise (bit 0) or fall (bit 1) enable of this channel's mode field.
      always_comb begin
        update    = 1'b0;
        tick_next = 1'b0;
        if ((sync_bit != level_r) && (cnt_r == CNT_LAST)) begin
          update = 1'b1;
        end
        if (update) begin
          tick_next = sync_bit ? mode[2*g] : mode[2*g+1];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_r  <= '0;
          cnt_r   <= '0;
          level_r <= 1'b0;
          tick_r  <= 1'b0;
          pend_r  <= 1'b0;
          ovr_r   <= 1'b0;
        end else begin
          sync_r <= {sync_r[SYNC_STAGES-2:0], signal[g]};

          if (sync_bit == level_r) begin
            cnt_r <= '0;
          end else if (update) begin
            cnt_r   <= '0;
            level_r <= sync_bit;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end

          tick_r <= tick_next;
          // A new event outranks a simultaneous clear for pending.
          pend_r <= tick_next | (pend_r & ~clr[g]);

          if (tick_next && pend_r && !clr[g]) begin
            ovr_r <= 1'b1;
          end else if (clr[g]) begin
            ovr_r <= 1'b0;
          end
        end
      end

      assign level[g]   = level_r;
      assign tick[g]    = tick_r;
      assign pending[g] = pend_r;
      assign overrun[g] = ovr_r;
    end
  endgenerate

  assign irq = |pending;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Randomized bench for edge_detect_multi against a delay-line / window model.
module tb_edge_detect_multi;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int DB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   signal;
  logic [2*CH-1:0] mode;
  logic [CH-1:0]   clr;
  logic [CH-1:0]   level;
  logic [CH-1:0]   tick;
  logic [CH-1:0]   pending;
  logic [CH-1:0]   overrun;
  logic            irq;

  int n_cmp = 0;
  int n_bad = 0;

  edge_detect_multi #(
    .CHANNELS        (CH),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .signal  (signal),
    .mode    (mode),
    .clr     (clr),
    .level   (level),
    .tick    (tick),
    .pending (pending),
    .overrun (overrun),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // Reference model: raw input delayed by SS edges, level flips once the
  // last DB observed samples all disagree with it.
  bit rawq [CH][$];
  bit win  [CH][$];
  bit m_level [CH];
  bit m_tick  [CH];
  bit m_pend  [CH];
  bit m_ovr   [CH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      rawq[c].delete();
      win[c].delete();
      for (int j = 0; j < SS; j++) rawq[c].push_back(1'b0);
      for (int j = 0; j < DB; j++) win[c].push_back(1'b0);
      m_level[c] = 1'b0;
      m_tick[c]  = 1'b0;
      m_pend[c]  = 1'b0;
      m_ovr[c]   = 1'b0;
    end
  endfunction

  function automatic void model_step(input logic [CH-1:0] sig, input logic [2*CH-1:0] md,
                                     input logic [CH-1:0] cl);
    for (int c = 0; c < CH; c++) begin
      bit seen, upd, tk, rise;
      seen = rawq[c].pop_front();
      rawq[c].push_back(sig[c]);
      win[c].push_back(seen);
      if (win[c].size() > DB) void'(win[c].pop_front());
      upd = 1'b1;
      foreach (win[c][j]) if (win[c][j] == m_level[c]) upd = 1'b0;
      rise = !m_level[c];
      tk = upd && (rise ? md[2*c] : md[2*c+1]);
      if (tk && m_pend[c] && !cl[c]) m_ovr[c] = 1'b1;
      else if (cl[c])                m_ovr[c] = 1'b0;
      m_pend[c] = tk || (m_pend[c] && !cl[c]);
      m_tick[c] = tk;
      if (upd) m_level[c] = !m_level[c];
    end
  endfunction

  task automatic compare_all(input string phase);
    logic [CH-1:0] el, et, ep, eo;
    for (int c = 0; c < CH; c++) begin
      el[c] = m_level[c];
      et[c] = m_tick[c];
      ep[c] = m_pend[c];
      eo[c] = m_ovr[c];
    end
    check({phase, ".level"},   level,   el);
    check({phase, ".tick"},    tick,    et);
    check({phase, ".pending"}, pending, ep);
    check({phase, ".overrun"}, overrun, eo);
    check({phase, ".irq"},     irq,     |ep);
  endtask

  task automatic cycle(input string phase);
    @(posedge clk);
    model_step(signal, mode, clr);
    #1;
    compare_all(phase);
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst    = 1'b1;
    signal = '0;
    mode   = '0;
    clr    = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Clean rise on channel 0: level follows SS+DB-1 edges after first sample.
    mode   = 8'h55;
    signal = 4'b0001;
    n = 0;
    while (n < 20) begin
      cycle("latency");
      n++;
      if (level[0]) break;
    end
    check("latency_edges", n, SS + DB);
    repeat (3) cycle("settle");

    for (int k = 0; k < 2000; k++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 5) == 0) signal[c] = !signal[c];
        clr[c] = ($urandom_range(0, 11) == 0);
      end
      if ($urandom_range(0, 39) == 0) mode = 8'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("async_rst");
        @(posedge clk);
        #1;
        compare_all("in_rst");
        @(negedge clk);
        rst = 1'b0;
      end else begin
        cycle("random");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
